// File: rtl/req_ack_32bit_receiver.sv
// rtl/req_ack_32bit_receiver.sv - four-phase req/ack 32-bit receiver packing word pairs into a 64-bit AXI-Stream master
// Optional pending-half flush timer is compiled in with `define RX_TIMEOUT_EN.
module req_ack_32bit_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] recv_len,
  output logic [31:0] data_cnt,
  output logic [31:0] tlast_cnt,
  input  logic        request,
  input  logic [31:0] din,
  output logic        acknowledge,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  output logic        m_axis_hsked,
  output logic        o_rx_done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("req_ack_32bit_receiver: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] r_req_sync;
  logic [0:0]             r_state;
  logic                   r_half;
  logic [31:0]            r_hi;
  logic [31:0]            r_beat_cnt;
  logic [31:0]            r_len;

  logic        w_req_s;
  logic        w_out_free;
  logic        w_can_accept;
  logic        w_accept;
  logic        w_load;
  logic        w_hsked;
  logic        w_flush;
  logic [31:0] w_len_eff;
  logic        w_last_by_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_sync <= '0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], request};
    end
  end

  assign w_req_s      = r_req_sync[SYNC_STAGES-1];
  assign w_hsked      = m_axis_tvalid & m_axis_tready;
  assign w_out_free   = !m_axis_tvalid | m_axis_tready;
  // Withholding acknowledge on the second word is the only backpressure to the sender.
  assign w_can_accept = !r_half | w_out_free;
  assign w_accept     = (r_state == S_IDLE) & w_req_s & w_can_accept;
  assign w_load       = w_accept & r_half;

  // A frame's length is taken from recv_len on its first beat and held until it wraps.
  assign w_len_eff     = (r_beat_cnt == 32'd0) ? recv_len : r_len;
  assign w_last_by_cnt = (w_len_eff != 32'd0) && (r_beat_cnt == w_len_eff - 32'd1);

`ifdef RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] r_idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || !r_half || w_accept) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != IDLE_W'(TIMEOUT_CYCLES)) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign w_flush = r_half & (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES)) & w_out_free & !w_accept;
`else
  assign w_flush = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      acknowledge   <= 1'b0;
      r_half        <= 1'b0;
      r_hi          <= 32'd0;
      r_beat_cnt    <= 32'd0;
      r_len         <= 32'd0;
      m_axis_tdata  <= 64'd0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      data_cnt      <= 32'd0;
      tlast_cnt     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            acknowledge <= 1'b1;
            r_state     <= S_ACK;
          end
        end
        default: begin
          if (!w_req_s) begin
            acknowledge <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase

      if (w_accept && !r_half) begin
        r_hi   <= din;
        r_half <= 1'b1;
      end

      // A load in the same cycle as a handshake keeps tvalid high for back-to-back beats.
      if (w_load) begin
        m_axis_tdata  <= {r_hi, din};
        m_axis_tlast  <= w_last_by_cnt;
        m_axis_tvalid <= 1'b1;
        r_half        <= 1'b0;
        if (r_beat_cnt == 32'd0) begin
          r_len <= recv_len;
        end
        if (w_len_eff == 32'd0 || w_last_by_cnt) begin
          r_beat_cnt <= 32'd0;
        end else begin
          r_beat_cnt <= r_beat_cnt + 32'd1;
        end
      end else if (w_flush) begin
        m_axis_tdata  <= {r_hi, 32'h0};
        m_axis_tlast  <= 1'b1;
        m_axis_tvalid <= 1'b1;
        r_half        <= 1'b0;
        r_beat_cnt    <= 32'd0;
      end else if (w_hsked) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      if (w_hsked) begin
        data_cnt <= data_cnt + 32'd1;
        if (m_axis_tlast) begin
          tlast_cnt <= tlast_cnt + 32'd1;
        end
      end
    end
  end

  assign m_axis_hsked = w_hsked;
  assign o_rx_done    = w_hsked & m_axis_tlast;

endmodule

// File: tb/tb_req_ack_32bit_receiver.sv
// tb/tb_req_ack_32bit_receiver.sv - self-checking bench for req_ack_32bit_receiver
module tb_req_ack_32bit_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] recv_len;
  logic [31:0] data_cnt;
  logic [31:0] tlast_cnt;
  logic        request;
  logic [31:0] din;
  logic        acknowledge;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_hsked;
  logic        o_rx_done;

  int checks = 0;
  int errors = 0;
  int rx_done_seen = 0;
  bit rand_mode = 1'b0;

  logic [64:0] obs_q[$];
  logic [64:0] exp_q[$];
  logic [31:0] words[$];

  logic        p_stall = 1'b0;
  logic [64:0] p_beat  = '0;

  req_ack_32bit_receiver #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .recv_len     (recv_len),
    .data_cnt     (data_cnt),
    .tlast_cnt    (tlast_cnt),
    .request      (request),
    .din          (din),
    .acknowledge  (acknowledge),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_hsked (m_axis_hsked),
    .o_rx_done    (o_rx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat capture and AXIS hold-during-stall check.
  always @(negedge clk) begin
    if (!rst) begin
      if (p_stall) begin
        chk("stall_hold", {1'b0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b0, 1'b1, p_beat});
      end
      if (m_axis_tvalid && m_axis_tready) obs_q.push_back({m_axis_tlast, m_axis_tdata});
      if (o_rx_done) rx_done_seen++;
    end
    p_stall = !rst && m_axis_tvalid && !m_axis_tready;
    p_beat  = {m_axis_tlast, m_axis_tdata};
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    request = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    obs_q.delete();
    words.delete();
    rx_done_seen = 0;
    tick();
  endtask

  task automatic send_word(input logic [31:0] w, output int lat);
    int n;
    n = 0;
    din = w;
    request = 1'b1;
    while (!acknowledge && n < 200) begin
      tick();
      n++;
    end
    chk("ack_rise", 66'(acknowledge), 66'(1));
    request = 1'b0;
    for (int i = 0; i < 200 && acknowledge; i++) tick();
    chk("ack_fall", 66'(acknowledge), 66'(0));
    lat = n;
  endtask

  task automatic push_send(input logic [31:0] w);
    int lat;
    words.push_back(w);
    send_word(w, lat);
  endtask

  task automatic drain();
    rand_mode = 1'b0;
    m_axis_tready = 1'b1;
    repeat (10) tick();
  endtask

  // Reference: consecutive word pairs form beats; tlast on every len-th beat of the stream.
  task automatic compare_all(input string tag, input int len);
    int nlast;
    logic last;
    exp_q.delete();
    nlast = 0;
    for (int b = 0; b < words.size() / 2; b++) begin
      last = (len != 0) && ((b % len) == len - 1);
      if (last) nlast++;
      exp_q.push_back({last, words[2*b], words[2*b+1]});
    end
    chk({tag, "_nbeats"}, 66'(obs_q.size()), 66'(exp_q.size()));
    for (int b = 0; b < exp_q.size() && b < obs_q.size(); b++) begin
      chk({tag, "_beat"}, 66'(obs_q[b]), 66'(exp_q[b]));
    end
    chk({tag, "_data_cnt"}, 66'(data_cnt), 66'(exp_q.size()));
    chk({tag, "_tlast_cnt"}, 66'(tlast_cnt), 66'(nlast));
    chk({tag, "_rx_done"}, 66'(rx_done_seen), 66'(nlast));
  endtask

  initial begin
    int lat;
    int len;
    int npairs;
    logic [31:0] w;
    rst = 1'b1;
    recv_len = 32'd2;
    request = 1'b0;
    din = 32'd0;
    m_axis_tready = 1'b1;

    do_reset();
    chk("rst_ack", 66'(acknowledge), 66'(0));
    chk("rst_tvalid", 66'(m_axis_tvalid), 66'(0));
    chk("rst_tlast", 66'(m_axis_tlast), 66'(0));
    chk("rst_tdata", 66'(m_axis_tdata), 66'(0));
    chk("rst_data_cnt", 66'(data_cnt), 66'(0));
    chk("rst_tlast_cnt", 66'(tlast_cnt), 66'(0));
    chk("rst_rx_done", 66'(o_rx_done), 66'(0));

    // Directed pair of frames, with request-to-acknowledge latency
    words.push_back(32'h11111111);
    send_word(32'h11111111, lat);
    chk("ack_latency", 66'(lat), 66'(3));
    push_send(32'h22222222);
    push_send(32'h33333333);
    push_send(32'h44444444);
    drain();
    compare_all("len2", 2);

    // recv_len = 0: no tlast ever
    recv_len = 32'd0;
    do_reset();
    for (int i = 0; i < 6; i++) push_send(32'hA0000000 + 32'(i));
    drain();
    compare_all("len0", 0);

    // Backpressure: second word of next pair withheld while output stalled
    recv_len = 32'd2;
    do_reset();
    m_axis_tready = 1'b0;
    push_send(32'hC0C0C0C1);
    push_send(32'hC0C0C0C2);
    push_send(32'hC0C0C0C3);
    words.push_back(32'hC0C0C0C4);
    din = 32'hC0C0C0C4;
    request = 1'b1;
    repeat (20) tick();
    chk("stall_ack_withheld", 66'(acknowledge), 66'(0));
    chk("stall_tdata", 66'(m_axis_tdata), 66'(64'hC0C0C0C1C0C0C0C2));
    chk("stall_tvalid", 66'(m_axis_tvalid), 66'(1));
    m_axis_tready = 1'b1;
    for (int i = 0; i < 50 && !acknowledge; i++) tick();
    chk("stall_ack_resume", 66'(acknowledge), 66'(1));
    request = 1'b0;
    for (int i = 0; i < 50 && acknowledge; i++) tick();
    drain();
    compare_all("stall", 2);

    // Reset while acknowledge is high
    do_reset();
    push_send(32'h01010101);
    push_send(32'h02020202);
    drain();
    din = 32'h03030303;
    request = 1'b1;
    for (int i = 0; i < 50 && !acknowledge; i++) tick();
    chk("midrst_ack_before", 66'(acknowledge), 66'(1));
    rst = 1'b1;
    tick();
    chk("midrst_ack", 66'(acknowledge), 66'(0));
    chk("midrst_tvalid", 66'(m_axis_tvalid), 66'(0));
    chk("midrst_data_cnt", 66'(data_cnt), 66'(0));
    chk("midrst_tlast_cnt", 66'(tlast_cnt), 66'(0));
    do_reset();
    push_send(32'h5EED0001);
    push_send(32'h5EED0002);
    drain();
    compare_all("midrst_fresh", 2);

    // Randomized frames with random tready
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(0, 4);
      recv_len = 32'(len);
      do_reset();
      rand_mode = 1'b1;
      npairs = $urandom_range(3, 8);
      for (int i = 0; i < 2 * npairs; i++) begin
        w = $urandom;
        push_send(w);
      end
      drain();
      compare_all("random", len);
    end

    // Pending half-beat with no partner
    recv_len = 32'd0;
    do_reset();
    push_send(32'hABCD0123);
    for (int i = 0; i < 60 && obs_q.size() == 0; i++) tick();
`ifdef RX_TIMEOUT_EN
    chk("timeout_nbeats", 66'(obs_q.size()), 66'(1));
    if (obs_q.size() > 0) chk("timeout_beat", 66'(obs_q[0]), {1'b0, 1'b1, 64'hABCD012300000000});
    tick();
    chk("timeout_data_cnt", 66'(data_cnt), 66'(1));
    chk("timeout_tlast_cnt", 66'(tlast_cnt), 66'(1));
`else
    chk("no_timeout_nbeats", 66'(obs_q.size()), 66'(0));
    chk("no_timeout_tvalid", 66'(m_axis_tvalid), 66'(0));
    chk("no_timeout_data_cnt", 66'(data_cnt), 66'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
